data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder end of the CPU load/store interface. It accepts one load or store request at a time over a valid/ready handshake and executes it against an internal word-wide, single-port, synchronous-read array. It handles RV32 access widths (funct3 encoding), sign and zero extension, and sub-word stores by read-modify-write. It returns a held response carrying read data or an error flag. It replaces the combinational ram model when the core moves to a handshaked memory port.

## Interface
Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, ≥ 2; byte address space is DEPTH*4.

Ports:
- clk, input, 1, sole clock, rising edge.
- rst, input, 1, synchronous, active-high reset.
- req_valid, input, 1, request present.
- req_ready, output, 1, responder can accept; high only in IDLE.
- req_load, input, 1, request is a load.
- req_store, input, 1, request is a store.
- req_access, input, 3, funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr, input, 32, byte address.
- req_wdata, input, 32, store data; the low byte or halfword is used for B/H.
- rsp_valid, output, 1, response present; held until accepted.
- rsp_ready, input, 1, requester accepts the response.
- rsp_rdata, output, 32, extended load data; 0 for stores and errors.
- rsp_err, output, 1, request was rejected; the array is untouched.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: on req_valid && req_ready, capture all req_* fields, then classify the request:
  - Error, going to RESP with rsp_err=1:
    - req_load == req_store (both or neither set).
    - Illegal funct3: loads allow only 000/001/010/100/101; stores allow only 000/001/010.
    - Misaligned: H/HU with addr[0]≠0, W with addr[1:0]≠0.
    - Out of range: addr ≥ DEPTH*4.
  - Load → READ.
  - Word store → WRITE.
  - B/H store → READ.
- READ: the array returns the word at addr[31:2].
  - Load: select the byte or halfword by addr[1:0], little-endian; sign-extend for B/H, zero-extend for BU/HU. Latch into rsp_rdata, go to RESP.
  - Sub-word store: merge the new byte or halfword into the returned word, go to WRITE.
- WRITE: write the (merged) word, go to RESP with rsp_rdata=0 and rsp_err=0.
- RESP: rsp_valid=1; rsp_rdata and rsp_err are stable. On rsp_ready, go to IDLE.
- Only one request is outstanding. No request is accepted in the cycle the response is consumed.

## Timing
- Reset values: req_ready=0 during rst, then 1 in IDLE; rsp_valid=0; rsp_rdata=0; rsp_err=0; state=IDLE. Array contents are not cleared.
- Request accepted at edge T (the cycle where req_valid && req_ready):
  - Error: rsp_valid at T+1.
  - Load or word store: rsp_valid at T+2.
  - Sub-word store: rsp_valid at T+3.
- Stores become visible to a load accepted after that store's response handshake.
- rsp_ready held high gives back-to-back throughput of one request per (latency+1) cycles. The earliest next accept is the cycle after the response handshake.
- rst in any state takes priority. It returns the FSM to IDLE and suppresses an array write in that same cycle. A partially started sub-word store leaves the target word unchanged.
- req_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.

## Structure
- Shared package mem_pkg holds:
  - access code constants ACC_B, ACC_H, ACC_W, ACC_BU, ACC_HU;
  - state enum rsp_state_t;
  - a helper function for load extension.
- Sub-module mem_array: single-port word RAM, DEPTH×32, synchronous read, write enable, no reset.
- Alignment/range classification, merge and extension logic live in data_mem_responder.

## Test plan
- Word round-trip: SW 0xDEADBEEF @0x10, then LW @0x10. Store response at T+2, err=0. Load rsp_rdata=0xDEADBEEF at T+2.
- Sub-word store and extension:
  - Preload 0x11223344 @0x20.
  - SB 0xA5 @0x21; LW @0x20 → 0x1122A544.
  - LB @0x21 → 0xFFFFFFA5; LBU @0x21 → 0x000000A5.
  - SH 0x8001 @0x22; LH @0x22 → 0xFFFF8001; LHU @0x22 → 0x00008001.
- Errors respond at T+1 with rsp_err=1, rsp_rdata=0, and a following LW shows memory unchanged:
  - LW @0x02;
  - LH @0x01;
  - store with funct3=100;
  - load and store both set;
  - LW @DEPTH*4.
- Backpressure: hold rsp_ready=0 for 5 cycles after LW. rsp_valid and rsp_rdata stay stable, req_ready stays 0, and a req_valid offered meanwhile is not accepted.
- Reset mid-operation: assert rst in the WRITE cycle of SB 0xFF @0x30, which was preloaded with 0. After reset, LW @0x30 returns 0. All outputs read 0 during rst.
- Randomized mix against a byte-array reference model: 500 mixed requests with random rsp_ready stalls, zero mismatches.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder: access-width codes,
// responder FSM states and the load extension helper.
package mem_pkg;

    // RV32 funct3 access codes
    localparam logic [2:0] ACC_B  = 3'b000;
    localparam logic [2:0] ACC_H  = 3'b001;
    localparam logic [2:0] ACC_W  = 3'b010;
    localparam logic [2:0] ACC_BU = 3'b100;
    localparam logic [2:0] ACC_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } rsp_state_t;

    // Pick the addressed byte/halfword out of a little-endian word and
    // sign- or zero-extend it according to the access code.
    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [2:0]  acc,
        input logic [1:0]  offset
    );
        logic [7:0]  byte_val;
        logic [15:0] half_val;
        logic [31:0] result;
        byte_val = word[{offset, 3'b000} +: 8];
        half_val = word[{offset[1], 4'b0000} +: 16];
        case (acc)
            ACC_B:   result = {{24{byte_val[7]}}, byte_val};
            ACC_BU:  result = {24'h000000, byte_val};
            ACC_H:   result = {{16{half_val[15]}}, half_val};
            ACC_HU:  result = {16'h0000, half_val};
            default: result = word;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port DEPTH x 32 word RAM with synchronous read and write enable.
// No reset: contents survive a responder reset.
module mem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_reg [DEPTH];
    logic [31:0] rdata_reg;

    // Write when enabled; always register the read of the addressed word
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[addr] <= wdata;
        end
        rdata_reg <= mem_reg[addr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU load/store port. Accepts one request at a time,
// classifies it, runs it against the word array (read-modify-write for
// byte/halfword stores) and holds the response until it is taken.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_access,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [32:0] BYTE_SPAN  = 33'(DEPTH) << 2;

    rsp_state_t      state_reg, state_next;
    logic            load_reg, load_next;
    logic [2:0]      acc_reg, acc_next;
    logic [AW+1:0]   addr_reg, addr_next;
    logic [31:0]     wdata_reg, wdata_next;
    logic [31:0]     rdata_reg, rdata_next;
    logic            err_reg, err_next;

    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [31:0]     mem_rdata;

    logic [3:0]      byte_en;
    logic [31:0]     store_rep;
    logic [31:0]     merged_word;

    // A request is rejected for ambiguous direction, an illegal width code,
    // misalignment, or an address beyond the array.
    function automatic logic req_is_bad(
        input logic        ld,
        input logic        st,
        input logic [2:0]  acc,
        input logic [31:0] addr
    );
        logic bad;
        bad = (ld == st);
        case (acc)
            ACC_B:   ;
            ACC_H:   bad = bad | addr[0];
            ACC_W:   bad = bad | (addr[1:0] != 2'b00);
            ACC_BU:  bad = bad | st;
            ACC_HU:  bad = bad | st | addr[0];
            default: bad = 1'b1;
        endcase
        if ({1'b0, addr} >= BYTE_SPAN) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (wdata_reg),
        .rdata (mem_rdata)
    );

    // Byte lanes touched by a sub-word store, and the store data replicated
    // across lanes so each lane can pick its own slice.
    always_comb begin
        byte_en   = 4'b1111;
        store_rep = wdata_reg;
        case (acc_reg)
            ACC_B: begin
                byte_en   = 4'b0001 << addr_reg[1:0];
                store_rep = {4{wdata_reg[7:0]}};
            end
            ACC_H: begin
                byte_en   = addr_reg[1] ? 4'b1100 : 4'b0011;
                store_rep = {2{wdata_reg[15:0]}};
            end
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged_word[8*gi +: 8] = byte_en[gi] ? store_rep[8*gi +: 8]
                                                        : mem_rdata[8*gi +: 8];
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Captured request fields and response data
    always_ff @(posedge clk) begin
        if (rst) begin
            load_reg  <= 1'b0;
            acc_reg   <= ACC_W;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            load_reg  <= load_next;
            acc_reg   <= acc_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

    // Next-state, capture and array control
    always_comb begin
        state_next = state_reg;
        load_next  = load_reg;
        acc_next   = acc_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        mem_addr   = addr_reg[AW+1:2];
        mem_we     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Address the array straight from the request so the word
                // is ready in READ.
                mem_addr = req_addr[AW+1:2];
                if (req_valid) begin
                    load_next  = req_load;
                    acc_next   = req_access;
                    addr_next  = req_addr[AW+1:0];
                    wdata_next = req_wdata;
                    rdata_next = '0;
                    err_next   = 1'b0;
                    if (req_is_bad(req_load, req_store, req_access, req_addr)) begin
                        err_next   = 1'b1;
                        state_next = ST_RESP;
                    end else if (req_load || (req_access != ACC_W)) begin
                        state_next = ST_READ;
                    end else begin
                        state_next = ST_WRITE;
                    end
                end
            end
            ST_READ: begin
                if (load_reg) begin
                    rdata_next = load_extend(mem_rdata, acc_reg, addr_reg[1:0]);
                    state_next = ST_RESP;
                end else begin
                    wdata_next = merged_word;
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Reset in this cycle must not corrupt the target word
                mem_we     = !rst;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are forced low while reset is asserted
    assign req_ready = (state_reg == ST_IDLE) && !rst;
    assign rsp_valid = (state_reg == ST_RESP) && !rst;
    assign rsp_rdata = rst ? 32'h0 : rdata_reg;
    assign rsp_err   = err_reg && !rst;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios from the test plan plus a
// randomized mix checked against a byte-addressed reference model.
module tb_data_mem_responder;
    import mem_pkg::*;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic        req_store;
    logic [2:0]  req_access;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ref_mem [DEPTH*4];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_load   (req_load),
        .req_store  (req_store),
        .req_access (req_access),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: byte array, access size from the width code,
    // arithmetic sign extension. Latency counts edges from accept to the
    // edge at which rsp_valid is first sampled high.
    task automatic model_step(input logic ld, input logic st, input logic [2:0] acc,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er, output int lat);
        int     size;
        logic   legal;
        longint v;
        size = (acc[1:0] == 2'd0) ? 1 : (acc[1:0] == 2'd1) ? 2 : 4;
        if (ld && !st)      legal = acc inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        else if (st && !ld) legal = acc inside {3'd0, 3'd1, 3'd2};
        else                legal = 1'b0;
        if ((addr % size) != 0) legal = 1'b0;
        if (longint'(addr) >= longint'(DEPTH) * 4) legal = 1'b0;
        rd = 32'h0;
        er = 1'b0;
        if (!legal) begin
            er  = 1'b1;
            lat = 1;
        end else if (ld) begin
            v = 0;
            for (int i = 0; i < size; i++) v += longint'(ref_mem[addr + i]) << (8 * i);
            if (!acc[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                v -= longint'(1) << (8 * size);
            rd  = v[31:0];
            lat = 2;
        end else begin
            for (int i = 0; i < size; i++) ref_mem[addr + i] = wd[8*i +: 8];
            lat = (size == 4) ? 2 : 3;
        end
    endtask

    // Drive one request through the handshake. lat=0 means never accepted,
    // lat=99 means no response within the bound.
    task automatic do_req(input logic ld, input logic st, input logic [2:0] acc,
                          input logic [31:0] addr, input logic [31:0] wd, input int stall,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        rd = 32'h0;
        er = 1'b0;
        req_load   = ld;
        req_store  = st;
        req_access = acc;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            lat = 0;
        end else begin
            step();
            req_valid = 1'b0;
            lat = 1;
            while (!rsp_valid && lat < 10) begin
                step();
                lat++;
            end
            if (!rsp_valid) begin
                lat = 99;
            end else begin
                rd = rsp_rdata;
                er = rsp_err;
                repeat (stall) step();
                rsp_ready = 1'b1;
                step();
                rsp_ready = 1'b0;
            end
        end
        $display("txn ld=%0b st=%0b acc=%0d addr=%08h wdata=%08h -> rdata=%08h err=%0b lat=%0d",
                 ld, st, acc, addr, wd, rd, er, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_checks++;
        if ({req_ready, rsp_valid, rsp_err} !== 3'b000 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%0b valid=%0b err=%0b rdata=%08h, required all 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: ready=%0b valid=%0b rdata=%08h err=%0b, required 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_word_roundtrip();
        logic [31:0] rd, mrd;
        logic        er, mer;
        int          lat, mlat;
        do_req(1'b0, 1'b1, ACC_W, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
        model_step(1'b0, 1'b1, ACC_W, 32'h10, 32'hDEADBEEF, mrd, mer, mlat);
        n_checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL sw_roundtrip: lat=%0d err=%0b rdata=%08h, required 2 0 00000000", lat, er, rd);
        end
        do_req(1'b1, 1'b0, ACC_W, 32'h10, 32'h0, 0, rd, er, lat);
        n_checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL lw_roundtrip: lat=%0d err=%0b rdata=%08h, required 2 0 deadbeef", lat, er, rd);
        end
    endtask

    task automatic test_subword();
        logic        ld, st;
        logic [2:0]  acc;
        logic [31:0] a, wd, exp_rd, rd, mrd;
        logic        er, mer;
        int          exp_lat, lat, mlat;
        for (int i = 0; i < 8; i++) begin
            ld = 1'b1; st = 1'b0; wd = 32'h0;
            acc = ACC_W; a = 32'h20; exp_rd = 32'h0; exp_lat = 2;
            case (i)
                0: begin ld = 1'b0; st = 1'b1; wd = 32'h11223344; end
                1: begin ld = 1'b0; st = 1'b1; acc = ACC_B; a = 32'h21; wd = 32'h000000A5; exp_lat = 3; end
                2: exp_rd = 32'h1122A544;
                3: begin acc = ACC_B;  a = 32'h21; exp_rd = 32'hFFFFFFA5; end
                4: begin acc = ACC_BU; a = 32'h21; exp_rd = 32'h000000A5; end
                5: begin ld = 1'b0; st = 1'b1; acc = ACC_H; a = 32'h22; wd = 32'h00008001; exp_lat = 3; end
                6: begin acc = ACC_H;  a = 32'h22; exp_rd = 32'hFFFF8001; end
                default: begin acc = ACC_HU; a = 32'h22; exp_rd = 32'h00008001; end
            endcase
            do_req(ld, st, acc, a, wd, 0, rd, er, lat);
            model_step(ld, st, acc, a, wd, mrd, mer, mlat);
            n_checks++;
            if (rd !== exp_rd || er !== 1'b0 || lat !== exp_lat) begin
                n_fail++;
                $display("FAIL subword_%0d: rdata=%08h err=%0b lat=%0d, required %08h 0 %0d",
                         i, rd, er, lat, exp_rd, exp_lat);
            end
        end
    endtask

    task automatic test_errors();
        logic        ld, st;
        logic [2:0]  acc;
        logic [31:0] a, follow, rd, mrd;
        logic        er, mer;
        int          lat, mlat;
        for (int i = 0; i < 6; i++) begin
            ld = 1'b1; st = 1'b0; acc = ACC_W; a = 32'h02; follow = 32'h10;
            case (i)
                0: ;
                1: begin acc = ACC_H; a = 32'h01; end
                2: begin ld = 1'b0; st = 1'b1; acc = 3'b100; a = 32'h20; follow = 32'h20; end
                3: begin st = 1'b1; a = 32'h20; follow = 32'h20; end
                4: a = 32'(DEPTH * 4);
                default: begin ld = 1'b0; a = 32'h20; follow = 32'h20; end
            endcase
            do_req(ld, st, acc, a, 32'hFFFFFFFF, 0, rd, er, lat);
            n_checks++;
            if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
                n_fail++;
                $display("FAIL error_%0d: err=%0b rdata=%08h lat=%0d, required 1 00000000 1", i, er, rd, lat);
            end
            do_req(1'b1, 1'b0, ACC_W, follow, 32'h0, 0, rd, er, lat);
            model_step(1'b1, 1'b0, ACC_W, follow, 32'h0, mrd, mer, mlat);
            n_checks++;
            if (rd !== mrd || er !== 1'b0) begin
                n_fail++;
                $display("FAIL error_%0d_unchanged: rdata=%08h err=%0b, required %08h 0", i, rd, er, mrd);
            end
        end
    endtask

    task automatic test_backpressure();
        int          n;
        logic [31:0] rd;
        logic        er;
        int          lat;
        req_load = 1'b1; req_store = 1'b0; req_access = ACC_W; req_addr = 32'h10; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin step(); n++; end
        step();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin step(); n++; end
        // Offer a store while the load response is stalled
        req_load = 1'b0; req_store = 1'b1; req_wdata = 32'h0BADF00D; req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0 || rsp_err !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_%0d: valid=%0b rdata=%08h ready=%0b err=%0b, required 1 deadbeef 0 0",
                         c, rsp_valid, rsp_rdata, req_ready, rsp_err);
            end
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: valid=%0b ready=%0b, required 0 1", rsp_valid, req_ready);
        end
        do_req(1'b1, 1'b0, ACC_W, 32'h10, 32'h0, 0, rd, er, lat);
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL backpressure_store_ignored: rdata=%08h, required deadbeef", rd);
        end
    endtask

    task automatic test_back_to_back();
        int accepts;
        accepts = 0;
        req_load = 1'b1; req_store = 1'b0; req_access = ACC_W; req_addr = 32'h10;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (req_valid && req_ready) accepts++;
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        step();
        n_checks++;
        if (accepts !== 4) begin
            n_fail++;
            $display("FAIL back_to_back: accepts in 12 cycles=%0d, required 4", accepts);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd, mrd;
        logic        er, mer;
        int          lat, mlat, n;
        do_req(1'b0, 1'b1, ACC_W, 32'h30, 32'h0, 0, rd, er, lat);
        model_step(1'b0, 1'b1, ACC_W, 32'h30, 32'h0, mrd, mer, mlat);
        req_load = 1'b0; req_store = 1'b1; req_access = ACC_B; req_addr = 32'h30;
        req_wdata = 32'h000000FF; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin step(); n++; end
        step();               // accepted -> READ
        req_valid = 1'b0;
        step();               // READ -> WRITE
        rst = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_err} !== 3'b000 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: ready=%0b valid=%0b err=%0b rdata=%08h, required all 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: ready=%0b valid=%0b, required 1 0", req_ready, rsp_valid);
        end
        do_req(1'b1, 1'b0, ACC_W, 32'h30, 32'h0, 0, rd, er, lat);
        n_checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_unchanged: rdata=%08h err=%0b, required 00000000 0", rd, er);
        end
    endtask

    task automatic test_random_mix();
        logic        ld, st;
        logic [2:0]  acc;
        logic [31:0] a, wd, rd, mrd;
        logic        er, mer;
        int          lat, mlat, stall;
        // Fill the working window so every in-range load reads known data
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            a  = 32'h100 + 32'(w * 4);
            do_req(1'b0, 1'b1, ACC_W, a, wd, 0, rd, er, lat);
            model_step(1'b0, 1'b1, ACC_W, a, wd, mrd, mer, mlat);
        end
        for (int k = 0; k < 500; k++) begin
            ld = 1'($urandom_range(0, 1));
            st = !ld;
            if ($urandom_range(0, 15) == 0) st = ld;
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0: acc = ACC_B;
                    1: acc = ACC_H;
                    2: acc = ACC_W;
                    3: acc = ACC_BU;
                    default: acc = ACC_HU;
                endcase
            end else begin
                acc = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 15) == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
            else                            a = 32'h100 + 32'($urandom_range(0, 63));
            wd    = $urandom;
            stall = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            do_req(ld, st, acc, a, wd, stall, rd, er, lat);
            model_step(ld, st, acc, a, wd, mrd, mer, mlat);
            n_checks++;
            if (rd !== mrd || er !== mer || lat !== mlat) begin
                n_fail++;
                $display("FAIL random_%0d: rdata=%08h err=%0b lat=%0d, required %08h %0b %0d",
                         k, rd, er, lat, mrd, mer, mlat);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_load   = 1'b0;
        req_store  = 1'b0;
        req_access = ACC_W;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;
        test_reset();
        test_word_roundtrip();
        test_subword();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_write();
        test_random_mix();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
